mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexer (inputs A/B/C/D, selects S1/S0, output Y) between four requesters.
- Drives S1/S0 directly and issues one-hot grants with a request/grant handshake.
- Changes the select one cycle before any grant is asserted, so Y has settled when the owner first sees its grant.
- A hold limit stops one requester from monopolising the mux.

Parameters:
MAX_HOLD, 8, maximum consecutive GRANT-state cycles for one owner while other requests are pending; legal range 1..(2^CNT_W - 1)
CNT_W, 4, width of the hold counter

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge
REQ  input  4  request per mux input; bit 0 = A, 1 = B, 2 = C, 3 = D; level-held until the requester is done
GNT  output  4  one-hot grant, registered; all zero when no owner
S1  output  1  mux select MSB, registered
S0  output  1  mux select LSB, registered; {S1,S0} = index of selected input
VALID  output  1  high exactly when GNT is non-zero; Y is valid for the owner
BUSY  output  1  high in SWITCH and GRANT states

Behaviour:
- Reset (RST_N low at any edge, including mid-grant or mid-switch):
  - Outputs: GNT=0000, S1=0, S0=0, VALID=0, BUSY=0.
  - Internal: state=IDLE, hold counter=0, last-owner pointer=3, so requester 0 has first priority.
- Round-robin pick: scan REQ starting at (last+1) mod 4 and wrapping; the first set bit wins.
- IDLE:
  - Outputs: GNT=0, VALID=0, BUSY=0; S1/S0 hold their previous value.
  - REQ=0000: stay in IDLE.
  - Any REQ bit set: at this edge, load {S1,S0}=winner and go to SWITCH.
- SWITCH (exactly one cycle when the winner holds its request):
  - Outputs: GNT=0, VALID=0, BUSY=1.
  - REQ[winner]=1: go to GRANT. GNT=onehot(winner), VALID=1, last=winner, counter=0.
  - REQ[winner]=0: re-pick from current REQ, starting from the unchanged last pointer.
    - If a new winner exists, stay in SWITCH and load the new {S1,S0}.
    - Otherwise go to IDLE.
- GRANT:
  - GNT and {S1,S0} are stable. The counter increments each cycle and saturates at MAX_HOLD-1.
  - REQ[owner]=0 and other REQ bits pending: go to SWITCH with the next round-robin winner. GNT drops to 0 at this edge.
  - REQ[owner]=0 and no other requests: go to IDLE. GNT=0, select held.
  - REQ[owner]=1, counter=MAX_HOLD-1, other requests pending: forced release. Go to SWITCH with the round-robin winner, which is never the owner because the scan starts at owner+1.
  - REQ[owner]=1, counter=MAX_HOLD-1, no other requests: keep the grant and reset the counter to 0. No gap cycle.
  - Otherwise stay in GRANT.
- Timing:
  - REQ to GNT latency is 2 cycles from IDLE.
  - Minimum gap between two different owners' grants is 1 cycle (SWITCH).
  - The grant is removed on the same edge that samples the owner's REQ low.
- Invariants:
  - GNT is zero or one-hot.
  - When GNT≠0, GNT = onehot({S1,S0}).
  - VALID = |GNT.
  - S1/S0 change only on entry to or within SWITCH, or at reset.
- REQ bits that change in the same cycle as a state decision are evaluated with the values sampled at that edge. No priority beyond round-robin.

Test Plan:
1. Reset: RST_N=0 for 2 cycles with REQ=1111 -> GNT=0000, S1S0=00, VALID=0, BUSY=0. Release reset -> cycle+1 S1S0=00 (SWITCH), cycle+2 GNT=0001.
2. Single request: REQ=0100 from IDLE at cycle 0 -> cycle 1 S1S0=10, GNT=0000, BUSY=1; cycle 2 GNT=0100, VALID=1. Drop REQ at cycle 6 -> GNT=0000, state IDLE, S1S0 stays 10.
3. Contention with MAX_HOLD=4: REQ=1111 held -> grants 0001,0010,0100,1000,0001. Each grant lasts 4 cycles, separated by one GNT=0000 cycle. S1S0 steps 00,01,10,11,00.
4. Sole requester past the limit: REQ=0010 held 20 cycles with MAX_HOLD=4 -> GNT=0010 continuously from cycle 2, no SWITCH gap, VALID stays 1.
5. Winner withdraws during SWITCH: last=3, REQ=1001 in IDLE -> SWITCH with S1S0=00. REQ[0] drops during SWITCH -> next cycle stays in SWITCH with S1S0=11, then GNT=1000.
6. Reset mid-grant: REQ=1000 in GRANT, RST_N=0 for 1 cycle -> next edge GNT=0000, S1S0=00, BUSY=0. After release with REQ=1000 still high -> GNT=1000 two cycles later.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// The select is moved one cycle ahead of the grant so Y is settled when the owner sees GNT.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       S1,
  output logic       S0,
  output logic       VALID,
  output logic       BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWITCH, ST_GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state, w_state_next;
  logic [1:0]       r_sel, w_sel_next;
  logic [1:0]       r_last, w_last_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_gnt, w_gnt_next;
  logic [1:0]       w_pick;
  logic [3:0]       w_others;

  // Scan from last+1 upward with wrap; later (lower k) iterations take priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k + 1);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign w_pick   = rr_pick(REQ, r_last);
  assign w_others = REQ & ~(4'b0001 << r_last);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_gnt   <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
      r_gnt   <= w_gnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    w_gnt_next   = r_gnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt_next = 4'b0000;
        if (|REQ) begin
          w_sel_next   = w_pick;
          w_state_next = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        w_gnt_next = 4'b0000;
        if (REQ[r_sel]) begin
          w_gnt_next   = 4'b0001 << r_sel;
          w_last_next  = r_sel;
          w_cnt_next   = '0;
          w_state_next = ST_GRANT;
        end else if (|REQ) begin
          w_sel_next = w_pick;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!REQ[r_last]) begin
          w_gnt_next = 4'b0000;
          if (|w_others) begin
            w_sel_next   = w_pick;
            w_state_next = ST_SWITCH;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (r_cnt == HOLD_LAST) begin
          // Owner still wants the mux: force release only if someone else is waiting.
          if (|w_others) begin
            w_gnt_next   = 4'b0000;
            w_sel_next   = w_pick;
            w_state_next = ST_SWITCH;
          end else begin
            w_cnt_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_gnt_next   = 4'b0000;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign GNT   = r_gnt;
  assign S1    = r_sel[1];
  assign S0    = r_sel[0];
  assign VALID = |r_gnt;
  assign BUSY  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD=4): stimulus pushes the expected
// post-edge outputs into a queue, a monitor pops and compares one entry per clock.
module tb_mux4_rr_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       S1, S0, VALID, BUSY;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .GNT(GNT),
    .S1(S1), .S0(S0), .VALID(VALID), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic step(input logic rst, input logic [3:0] req,
                      input logic [3:0] g, input logic [1:0] s, input logic b);
    exp_t e;
    @(negedge CLK);
    RST_N = rst;
    REQ   = req;
    e.gnt = g; e.sel = s; e.busy = b;
    exp_q.push_back(e);
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic v;
      e = exp_q.pop_front();
      v = |e.gnt;
      checks++;
      if (GNT !== e.gnt || {S1, S0} !== e.sel || VALID !== v || BUSY !== e.busy) begin
        errors++;
        $display("FAIL vec%0d: got gnt=%b sel=%b%b valid=%b busy=%b, want gnt=%b sel=%b valid=%b busy=%b",
                 vec_no, GNT, S1, S0, VALID, BUSY, e.gnt, e.sel, v, e.busy);
      end else begin
        $display("vec%0d ok: gnt=%b sel=%b%b valid=%b busy=%b", vec_no, GNT, S1, S0, VALID, BUSY);
      end
      vec_no++;
    end
  end

  initial begin
    int wait_cycles;
    RST_N = 1'b0;
    REQ   = 4'b0000;

    // Reset with all requests high, then requester 0 wins first.
    step(0, 4'b1111, 4'b0000, 2'b00, 0);
    step(0, 4'b1111, 4'b0000, 2'b00, 0);
    step(1, 4'b1111, 4'b0000, 2'b00, 1);

    // Full contention: 4-cycle grants, one SWITCH gap, select walks 00,01,10,11,00.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) step(1, 4'b1111, 4'b0001 << r, 2'(r), 1);
      step(1, 4'b1111, 4'b0000, 2'(r + 1), 1);
    end
    step(1, 4'b1111, 4'b0001, 2'b00, 1);

    // Single request C from reset state; drop after six cycles, select held in IDLE.
    step(0, 4'b0000, 4'b0000, 2'b00, 0);
    step(1, 4'b0100, 4'b0000, 2'b10, 1);
    for (int k = 0; k < 5; k++) step(1, 4'b0100, 4'b0100, 2'b10, 1);
    step(1, 4'b0000, 4'b0000, 2'b10, 0);
    step(1, 4'b0000, 4'b0000, 2'b10, 0);

    // Sole requester B past the hold limit: no gap.
    step(1, 4'b0010, 4'b0000, 2'b01, 1);
    for (int k = 0; k < 19; k++) step(1, 4'b0010, 4'b0010, 2'b01, 1);
    step(1, 4'b0000, 4'b0000, 2'b01, 0);

    // Winner A withdraws during SWITCH; D is picked instead.
    step(0, 4'b0000, 4'b0000, 2'b00, 0);
    step(1, 4'b1001, 4'b0000, 2'b00, 1);
    step(1, 4'b1000, 4'b0000, 2'b11, 1);
    step(1, 4'b1000, 4'b1000, 2'b11, 1);

    // Reset mid-grant, then D regains after two cycles.
    step(0, 4'b1000, 4'b0000, 2'b00, 0);
    step(1, 4'b1000, 4'b0000, 2'b11, 1);
    step(1, 4'b1000, 4'b1000, 2'b11, 1);

    // Owner releases with others pending: rotation continues from the owner.
    step(1, 4'b0011, 4'b0000, 2'b00, 1);
    step(1, 4'b0011, 4'b0001, 2'b00, 1);
    step(1, 4'b0010, 4'b0000, 2'b01, 1);
    step(1, 4'b0010, 4'b0010, 2'b01, 1);
    step(1, 4'b0000, 4'b0000, 2'b01, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge CLK);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
